text_cell_tracker: RTL and testbench

Sequential, parametrised successor to the combinational pixel-to-text-cell mapper. It tracks the raster with incremental counters instead of dividers, so no divide or multiply logic sits in the pixel path. It supports arbitrary cell sizes, screen dimensions and a hardware vertical scroll (row wrap). It sits between the VGA timing generator and the text RAM / glyph ROM address path, and its outputs are registered with 1-cycle latency.

---
 rtl/text_pkg.sv | 14 +
 rtl/text_cell_tracker_wrap_counter.sv | 49 ++++
 rtl/text_cell_tracker.sv | 168 ++++++++++++++++
 tb/tb_text_cell_tracker.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/text_pkg.sv
// Shared defaults and width helpers for the text-cell raster tracker.
package text_pkg;

  localparam int CHAR_W_DEF = 8;
  localparam int CHAR_H_DEF = 16;
  localparam int COLS_DEF   = 80;
  localparam int ROWS_DEF   = 30;

  // Bits needed to hold 0..n-1, never less than one so degenerate sizes stay legal.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/text_cell_tracker_wrap_counter.sv
// Modulo-MAX counter with clear, load and increment; o_wrap flags an increment out of MAX-1.
module wrap_counter
  import text_pkg::*;
#(
  parameter int MAX = 8,
  parameter int W   = width_of(MAX)
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_inc,
  output logic [W-1:0] o_count,
  output logic         o_wrap
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic         at_max_s;

  assign at_max_s = (count_q == W'(MAX - 1));
  assign o_wrap   = i_inc && at_max_s;
  assign o_count  = count_q;

  // Next count: clear beats load beats increment.
  always_comb begin
    count_d = count_q;
    if (i_clr) begin
      count_d = {W{1'b0}};
    end else if (i_load) begin
      count_d = i_load_val;
    end else if (i_inc) begin
      count_d = at_max_s ? {W{1'b0}} : count_q + W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/text_cell_tracker.sv
// Raster-to-text-cell tracker: incremental counters replace dividers, supports row scroll.
// Outputs describe the pixel presented one cycle earlier.
module text_cell_tracker
  import text_pkg::*;
#(
  parameter int CHAR_W = CHAR_W_DEF,
  parameter int CHAR_H = CHAR_H_DEF,
  parameter int COLS   = COLS_DEF,
  parameter int ROWS   = ROWS_DEF,
  parameter int IDX_W  = width_of(COLS * ROWS),
  parameter int PIX_W  = width_of(CHAR_W * CHAR_H),
  parameter int ROW_W  = width_of(ROWS)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_frame_start,
  input  logic             i_line_end,
  input  logic             i_active,
  input  logic [ROW_W-1:0] i_scroll_row,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_char_index,
  output logic [PIX_W-1:0] o_char_pixel_idx,
  output logic             o_cell_first
);

  localparam int XS_W  = width_of(CHAR_W);
  localparam int YS_W  = width_of(CHAR_H);
  localparam int COL_W = width_of(COLS + 1);

  logic             fs_s, act_s, le_s;
  logic [XS_W-1:0]  x_sub_s;
  logic             x_wrap_s;
  logic [YS_W-1:0]  y_sub_s;
  logic             y_wrap_s;
  logic [ROW_W-1:0] row_s;
  logic             row_wrap_s;
  logic [ROW_W-1:0] scroll_eff_s;
  logic             in_cols_s;
  logic             unused_s;

  logic [COL_W-1:0] col_q, col_d;
  logic [IDX_W-1:0] row_base_q, row_base_d;
  logic [PIX_W-1:0] pix_base_q, pix_base_d;
  logic             armed_q, armed_d;
  logic             valid_q, valid_d;
  logic             cell_first_q, cell_first_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [PIX_W-1:0] pixel_q, pixel_d;

  // Frame start overrides both the pixel capture and the line advance.
  assign fs_s         = i_frame_start;
  assign act_s        = i_active && !i_frame_start;
  assign le_s         = i_line_end && !i_frame_start;
  assign scroll_eff_s = (int'(i_scroll_row) < ROWS) ? i_scroll_row : {ROW_W{1'b0}};
  assign in_cols_s    = armed_q && (col_q < COL_W'(COLS));
  assign unused_s     = ^{y_sub_s, row_s};

  wrap_counter #(.MAX(CHAR_W), .W(XS_W)) u_x_sub (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_clr      (fs_s || le_s),
    .i_load     (1'b0),
    .i_load_val ({XS_W{1'b0}}),
    .i_inc      (act_s),
    .o_count    (x_sub_s),
    .o_wrap     (x_wrap_s)
  );

  wrap_counter #(.MAX(CHAR_H), .W(YS_W)) u_y_sub (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_clr      (fs_s),
    .i_load     (1'b0),
    .i_load_val ({YS_W{1'b0}}),
    .i_inc      (le_s),
    .o_count    (y_sub_s),
    .o_wrap     (y_wrap_s)
  );

  wrap_counter #(.MAX(ROWS), .W(ROW_W)) u_row (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_clr      (1'b0),
    .i_load     (fs_s),
    .i_load_val (scroll_eff_s),
    .i_inc      (y_wrap_s),
    .o_count    (row_s),
    .o_wrap     (row_wrap_s)
  );

  // Column, base accumulators and output capture for the current cycle.
  always_comb begin
    col_d        = col_q;
    row_base_d   = row_base_q;
    pix_base_d   = pix_base_q;
    armed_d      = armed_q;
    valid_d      = 1'b0;
    cell_first_d = 1'b0;
    index_d      = index_q;
    pixel_d      = pixel_q;
    if (fs_s) begin
      col_d      = {COL_W{1'b0}};
      row_base_d = IDX_W'(int'(scroll_eff_s) * COLS);
      pix_base_d = {PIX_W{1'b0}};
      armed_d    = 1'b1;
    end else begin
      if (act_s) begin
        valid_d      = in_cols_s;
        cell_first_d = in_cols_s && (x_sub_s == {XS_W{1'b0}});
        if (in_cols_s) begin
          index_d = row_base_q + IDX_W'(col_q);
          pixel_d = pix_base_q + PIX_W'(x_sub_s);
        end else begin
          index_d = index_q;
          pixel_d = pixel_q;
        end
        if (x_wrap_s && (col_q != COL_W'(COLS))) begin
          col_d = col_q + COL_W'(1);
        end else begin
          col_d = col_q;
        end
      end else begin
        valid_d = 1'b0;
      end
      // Line advance applies after any pixel captured in the same cycle.
      if (le_s) begin
        col_d = {COL_W{1'b0}};
        if (y_wrap_s) begin
          pix_base_d = {PIX_W{1'b0}};
          row_base_d = row_wrap_s ? {IDX_W{1'b0}} : row_base_q + IDX_W'(COLS);
        end else begin
          pix_base_d = pix_base_q + PIX_W'(CHAR_W);
        end
      end else begin
        pix_base_d = pix_base_q;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      col_q        <= {COL_W{1'b0}};
      row_base_q   <= {IDX_W{1'b0}};
      pix_base_q   <= {PIX_W{1'b0}};
      armed_q      <= 1'b0;
      valid_q      <= 1'b0;
      cell_first_q <= 1'b0;
      index_q      <= {IDX_W{1'b0}};
      pixel_q      <= {PIX_W{1'b0}};
    end else begin
      col_q        <= col_d;
      row_base_q   <= row_base_d;
      pix_base_q   <= pix_base_d;
      armed_q      <= armed_d;
      valid_q      <= valid_d;
      cell_first_q <= cell_first_d;
      index_q      <= index_d;
      pixel_q      <= pixel_d;
    end
  end

  assign o_valid          = valid_q;
  assign o_cell_first     = cell_first_q;
  assign o_char_index     = index_q;
  assign o_char_pixel_idx = pixel_q;

endmodule

// File: tb/tb_text_cell_tracker.sv
// Bench for text_cell_tracker: default geometry and a small 6x10 / 4x3 geometry share one stimulus stream.
module tb_text_cell_tracker;

  typedef struct packed {
    logic v;
    logic cf;
    int   idx;
    int   pix;
  } pred_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fs = 1'b0, le = 1'b0, act = 1'b0;
  logic [4:0] scroll = 5'd0;

  logic        a_valid, a_cf, b_valid, b_cf;
  logic [11:0] a_idx;
  logic [6:0]  a_pix;
  logic [3:0]  b_idx;
  logic [5:0]  b_pix;

  int    nvec = 0, nfail = 0;
  int    mx = 0, my = 0;
  logic [4:0] msc = 5'd0;
  bit    armed = 1'b0, started = 1'b0;
  pred_t ea = '0, eb = '0;

  always #5 clk = ~clk;

  text_cell_tracker dut_a (
    .i_clk(clk), .i_reset(rst), .i_frame_start(fs), .i_line_end(le), .i_active(act),
    .i_scroll_row(scroll), .o_valid(a_valid), .o_char_index(a_idx),
    .o_char_pixel_idx(a_pix), .o_cell_first(a_cf)
  );

  text_cell_tracker #(.CHAR_W(6), .CHAR_H(10), .COLS(4), .ROWS(3)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_frame_start(fs), .i_line_end(le), .i_active(act),
    .i_scroll_row(scroll[1:0]), .o_valid(b_valid), .o_char_index(b_idx),
    .o_char_pixel_idx(b_pix), .o_cell_first(b_cf)
  );

  // Pixel (x,y) counted from the frame start, mapped to a cell by plain division.
  function automatic pred_t predict(input int cw, input int ch, input int cols, input int rows,
                                    input int sc, input int x, input int y, input bit arm,
                                    input pred_t prev);
    pred_t r;
    int    s;
    r    = prev;
    s    = (sc < rows) ? sc : 0;
    r.v  = arm && ((x / cw) < cols);
    r.cf = r.v && ((x % cw) == 0);
    if (r.v) begin
      r.idx = ((s + y / ch) % rows) * cols + x / cw;
      r.pix = (y % ch) * cw + x % cw;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      ea <= '0; eb <= '0; mx <= 0; my <= 0; msc <= 5'd0; armed <= 1'b0; started <= 1'b1;
    end else if (fs) begin
      ea.v <= 1'b0; ea.cf <= 1'b0; eb.v <= 1'b0; eb.cf <= 1'b0;
      mx <= 0; my <= 0; msc <= scroll; armed <= 1'b1;
    end else begin
      if (act) begin
        ea <= predict(8, 16, 80, 30, int'(msc), mx, my, armed, ea);
        eb <= predict(6, 10, 4, 3, int'(msc[1:0]), mx, my, armed, eb);
        mx <= mx + 1;
      end else begin
        ea.v <= 1'b0; ea.cf <= 1'b0; eb.v <= 1'b0; eb.cf <= 1'b0;
      end
      if (le) begin
        mx <= 0;
        my <= my + 1;
      end
    end
  end

  task automatic cmp(input string name, input int actual, input int expected);
    nvec++;
    if (actual !== expected) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      cmp("a_valid", int'(a_valid), int'(ea.v));
      cmp("a_cell_first", int'(a_cf), int'(ea.cf));
      cmp("a_index", int'(a_idx), ea.idx);
      cmp("a_pix", int'(a_pix), ea.pix);
      cmp("b_valid", int'(b_valid), int'(eb.v));
      cmp("b_cell_first", int'(b_cf), int'(eb.cf));
      cmp("b_index", int'(b_idx), eb.idx);
      cmp("b_pix", int'(b_pix), eb.pix);
    end
  end

  task automatic tick(input logic a, input logic l, input logic f);
    act = a; le = l; fs = f;
    @(posedge clk);
    #1;
    act = 1'b0; le = 1'b0; fs = 1'b0;
  endtask

  // Hand-computed expectations, checked against both the DUT and the model.
  task automatic lit_a(input string name, input int idx, input int pix, input int v);
    cmp({name, "_a_idx"}, int'(a_idx), idx);
    cmp({name, "_a_pix"}, int'(a_pix), pix);
    cmp({name, "_a_valid"}, int'(a_valid), v);
    cmp({name, "_model_a_idx"}, ea.idx, idx);
    cmp({name, "_model_a_valid"}, int'(ea.v), v);
  endtask

  task automatic lit_b(input string name, input int idx, input int pix, input int v);
    cmp({name, "_b_idx"}, int'(b_idx), idx);
    cmp({name, "_b_pix"}, int'(b_pix), pix);
    cmp({name, "_b_valid"}, int'(b_valid), v);
    cmp({name, "_model_b_idx"}, eb.idx, idx);
  endtask

  initial begin
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    lit_a("reset", 0, 0, 0);
    lit_b("reset", 0, 0, 0);
    cmp("reset_a_cf", int'(a_cf), 0);

    // Line 0 of a frame with no scroll.
    scroll = 5'd0;
    tick(1'b0, 1'b0, 1'b1);
    for (int x = 0; x < 640; x++) begin
      tick(1'b1, 1'b0, 1'b0);
      if (x == 0) begin
        lit_a("x0", 0, 0, 1);
        cmp("x0_a_cf", int'(a_cf), 1);
      end
      if (x == 9)   lit_a("x9", 1, 1, 1);
      if (x == 639) lit_a("x639", 79, 7, 1);
      if (x == 23)  lit_b("b_x23", 3, 5, 1);
      if (x >= 24 && x <= 29) lit_b("b_overflow", 3, 5, 0);
    end
    for (int n = 0; n < 17; n++) tick(1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    lit_a("line17", 80, 8, 1);
    lit_b("b_line17", 4, 42, 1);
    tick(1'b0, 1'b1, 1'b0);

    // Pixel and line end in the same cycle at the last cell.
    tick(1'b0, 1'b0, 1'b1);
    for (int x = 0; x < 639; x++) tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    lit_a("coincide", 79, 7, 1);
    tick(1'b1, 1'b0, 1'b0);
    lit_a("after_coincide", 0, 8, 1);
    tick(1'b0, 1'b1, 1'b0);

    // Scroll to the last row, then wrap to row 0.
    scroll = 5'd29;
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0);
    lit_a("scroll29", 2320, 0, 1);
    lit_b("b_scroll29", 4, 0, 1);
    for (int n = 0; n < 16; n++) tick(1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    lit_a("scroll29_wrap", 0, 0, 1);
    tick(1'b0, 1'b1, 1'b0);

    // Out-of-range scroll falls back to row 0.
    scroll = 5'd31;
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0);
    lit_a("scroll31", 0, 0, 1);
    lit_b("b_scroll31", 0, 0, 1);
    tick(1'b0, 1'b1, 1'b0);

    // Reset in the middle of a line.
    scroll = 5'd0;
    tick(1'b0, 1'b0, 1'b1);
    for (int x = 0; x < 100; x++) tick(1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    tick(1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    lit_a("midreset", 0, 0, 0);
    lit_b("midreset", 0, 0, 0);
    for (int x = 0; x < 20; x++) begin
      tick(1'b1, 1'b0, 1'b0);
      cmp("post_reset_a_valid", int'(a_valid), 0);
    end
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0);
    lit_a("rearmed", 0, 0, 1);
    tick(1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
